regfile_source_map: RTL
=======================

// Module: regfile_source_map
// PURPOSE
//  Rename-source tracker: per architectural register, records the ROB id of the youngest queued producer.
//  Drives rf_source, which regfileValid uses to validate committed registers, and supplies operand tags at queue.
//  Keeps branch checkpoints so a branch miss restores the map in one cycle.
// PARAMETERS
//  AREGS     128  architectural registers (r0 hardwired, never pending)
//  QSLOTS    4    queue slots per cycle
//  RBITS     4    ROB id width (RENTRIES = 2**RBITS)
//  NCHKPT    4    branch checkpoints, power of two
// PORTS
//  clk          in   1            clock
//  rst          in   1            synchronous, active-high reset
//  slot_v       in   QSLOTS       slot i queued this cycle
//  slot_rfw     in   QSLOTS       slot i writes register slot_rd[i]
//  slot_rd      in   7 x QSLOTS   destination register per slot
//  slot_rid     in   RBITS x QSLOTS  ROB id assigned to slot i
//  slot_br      in   QSLOTS       slot i is a branch needing a checkpoint (at most one bit set)
//  br_ok        in   1            oldest outstanding branch resolved correct: free oldest checkpoint
//  branchmiss   in   1            restore from checkpoint miss_chk
//  miss_chk     in   log2(NCHKPT) checkpoint index of the mispredicted branch
//  commit_v     in   4            commit bus valid, ports 0..3
//  commit_tgt   in   7 x 4        committed target register
//  commit_id    in   RBITS x 4    committed ROB id
//  rf_source    out  (RBITS+1) x AREGS  {pend, id} per register, registered
//  chk_head     out  log2(NCHKPT) index the next branch receives (tagged into its ROB entry)
//  chk_full     out  1            count == NCHKPT; upstream must stall branches
// BEHAVIOUR
//  Reset: all rf_source = {0,0}; chk_head = chk_tail = 0; count = 0; chk_full = 0. Checkpoint contents don't care.
//  Queue (branchmiss=0): for each i with slot_v&slot_rfw and slot_rd!=0, map[rd] <= {1,slot_rid[i]}.
//   Same rd in several slots: highest-indexed slot wins. Visible on rf_source next cycle (1-cycle latency).
//  Commit: for port k, if map[tgt].pend and map[tgt].id==commit_id[k], clear pend. Same clear applied to every live checkpoint.
//   Commit and queue to same register in one cycle: queue wins (new producer).
//  Checkpoint alloc: slot_br[i] & slot_v[i] & !chk_full & !branchmiss -> ckpt[chk_head] <= map after applying slots 0..i queue
//   updates and this cycle's commit clears; chk_head++ (wraps mod NCHKPT).
//   slot_br with chk_full: ignored, assertion fires.
//  br_ok: chk_tail++, count--; br_ok with count==0 is ignored (assertion). Alloc + br_ok same cycle: count unchanged.
//  branchmiss: map <= ckpt[miss_chk] with this cycle's commit clears applied; chk_head <= miss_chk;
//   count <= (miss_chk - chk_tail) mod NCHKPT (that checkpoint and all younger freed).
//   All queue writes and allocs in that cycle dropped. br_ok in the same cycle still frees oldest (applied after head rewind).
//  r0 always {0,0}. Reset mid-miss: reset dominates, all state cleared.
//  chk_full is combinational from count (count==NCHKPT), count is log2(NCHKPT)+1 bits.
// STRUCTURE
//  any1_pkg: RBITS, QSLOTS, NCHKPT constants; typedef struct packed {logic pend; logic [RBITS-1:0] id;} rf_src_t.
//  Sub-module regfile_source_chkpt: NCHKPT x AREGS rf_src_t storage, write port (index, image), read port (miss_chk),
//   broadcast commit-clear on all entries. Top holds map, slot-priority merge, head/tail/count.
// TESTING
//  Reset, then slot0 rd=5 rid=3 -> next cycle rf_source[5]={1,3}; all others {0,0}.
//  Same cycle slot0 rd=7 rid=1, slot2 rd=7 rid=2 -> rf_source[7]={1,2}; commit id=1 tgt=7 later -> stays {1,2}; id=2 -> {0,2}.
//  slot0 rd=9 rid=4, slot1 branch, slot2 rd=9 rid=6 -> chk_head 0->1; branchmiss miss_chk=0 -> rf_source[9]={1,4}, chk_head=0, count=0.
//  Four branches without br_ok -> chk_full=1; fifth slot_br ignored, assertion; one br_ok -> chk_full=0 next cycle.
//  Checkpoint holds rf_source[3]={1,5}; commit id=5 tgt=3 same cycle as branchmiss -> restored rf_source[3]={0,5}.
//  Queue slot0 rd=0 rid=2 -> rf_source[0] stays {0,0}; rst asserted during branchmiss -> all {0,0}, count=0.

Source files
------------

// File: rtl/regfile_source_map_pkg.sv
// Shared constants and types for the rename-source tracker.
//   rf_src_t     : {pend, id} entry per architectural register
//   rf_map_t     : full map, one rf_src_t per architectural register
//   commit_clear : clears pend on every entry whose id matches a committing
//                  producer on that entry's register
package regfile_source_map_pkg;

  localparam int AREGS   = 128;
  localparam int QSLOTS  = 4;
  localparam int RBITS   = 4;
  localparam int NCHKPT  = 4;
  localparam int NCOMMIT = 4;
  localparam int RD_W    = $clog2(AREGS);
  localparam int CBITS   = $clog2(NCHKPT);

  typedef struct packed {
    logic             pend;
    logic [RBITS-1:0] id;
  } rf_src_t;

  typedef rf_src_t [AREGS-1:0]                rf_map_t;
  typedef logic [QSLOTS-1:0][RD_W-1:0]        slot_rd_t;
  typedef logic [QSLOTS-1:0][RBITS-1:0]       slot_rid_t;
  typedef logic [NCOMMIT-1:0][RD_W-1:0]       commit_tgt_t;
  typedef logic [NCOMMIT-1:0][RBITS-1:0]      commit_id_t;

  // Compares against the incoming map so that several ports retiring to the
  // same register all see the pre-commit value.
  function automatic rf_map_t commit_clear(input rf_map_t            m,
                                           input logic [NCOMMIT-1:0] v,
                                           input commit_tgt_t        tgt,
                                           input commit_id_t         id);
    rf_map_t r;
    r = m;
    for (int k = 0; k < NCOMMIT; k++) begin
      if (v[k] && m[tgt[k]].pend && (m[tgt[k]].id == id[k]))
        r[tgt[k]].pend = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_source_map_if.sv
// Bus bundle for the rename-source tracker.
//   slot_*       : per-slot queue info (valid, reg write, rd, ROB id, branch)
//   br_ok/branchmiss/miss_chk : branch resolution
//   commit_*     : 4-port commit bus
//   rf_source_o  : registered {pend,id} map
//   chk_head_o   : checkpoint index the next branch receives
//   chk_full_o   : all checkpoints in use
// master = upstream driver, slave = tracker.
interface regfile_source_map_if;
  import regfile_source_map_pkg::*;

  logic [QSLOTS-1:0]  slot_v_i;
  logic [QSLOTS-1:0]  slot_rfw_i;
  slot_rd_t           slot_rd_i;
  slot_rid_t          slot_rid_i;
  logic [QSLOTS-1:0]  slot_br_i;
  logic               br_ok_i;
  logic               branchmiss_i;
  logic [CBITS-1:0]   miss_chk_i;
  logic [NCOMMIT-1:0] commit_v_i;
  commit_tgt_t        commit_tgt_i;
  commit_id_t         commit_id_i;
  rf_map_t            rf_source_o;
  logic [CBITS-1:0]   chk_head_o;
  logic               chk_full_o;

  modport master (
    output slot_v_i, slot_rfw_i, slot_rd_i, slot_rid_i, slot_br_i,
           br_ok_i, branchmiss_i, miss_chk_i,
           commit_v_i, commit_tgt_i, commit_id_i,
    input  rf_source_o, chk_head_o, chk_full_o
  );

  modport slave (
    input  slot_v_i, slot_rfw_i, slot_rd_i, slot_rid_i, slot_br_i,
           br_ok_i, branchmiss_i, miss_chk_i,
           commit_v_i, commit_tgt_i, commit_id_i,
    output rf_source_o, chk_head_o, chk_full_o
  );

endinterface

// File: rtl/regfile_source_map_chkpt.sv
// Branch checkpoint storage: NCHKPT full copies of the source map.
//   clk          : clock
//   wr_en_i      : capture wr_img_i into entry wr_idx_i
//   wr_idx_i     : entry to write
//   wr_img_i     : map image to store
//   rd_idx_i     : entry to read (mispredicted branch)
//   rd_img_o     : stored image, combinational read
//   commit_*_i   : commit bus; clears are broadcast to every entry
// Contents are not reset; an entry is only read after it has been written.
module regfile_source_map_chkpt
  import regfile_source_map_pkg::*;
(
  input  logic               clk,
  input  logic               wr_en_i,
  input  logic [CBITS-1:0]   wr_idx_i,
  input  rf_map_t            wr_img_i,
  input  logic [CBITS-1:0]   rd_idx_i,
  output rf_map_t            rd_img_o,
  input  logic [NCOMMIT-1:0] commit_v_i,
  input  commit_tgt_t        commit_tgt_i,
  input  commit_id_t         commit_id_i
);

  rf_map_t ckpt_q [NCHKPT];
  rf_map_t ckpt_d [NCHKPT];

  // A freshly written image already carries this cycle's commit clears.
  always_comb begin
    for (int e = 0; e < NCHKPT; e++) begin
      if (wr_en_i && (wr_idx_i == CBITS'(e)))
        ckpt_d[e] = wr_img_i;
      else
        ckpt_d[e] = commit_clear(ckpt_q[e], commit_v_i, commit_tgt_i, commit_id_i);
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < NCHKPT; e++) ckpt_q[e] <= ckpt_d[e];
  end

  assign rd_img_o = ckpt_q[rd_idx_i];

endmodule

// File: rtl/regfile_source_map.sv
// Rename-source tracker: per architectural register, the ROB id of the
// youngest queued producer plus a pending flag.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_source_map_if.slave (queue slots, branch resolution,
//              commit bus, rf_source/chk_head/chk_full outputs)
// Branch checkpoints are kept in a circular buffer (head/tail/count); a miss
// restores the map from the checkpoint in one cycle.
module regfile_source_map
  import regfile_source_map_pkg::*;
(
  input logic clk,
  input logic rst,
  regfile_source_map_if.slave bus
);

  rf_map_t          map_q, map_d, map_c, map_n, img, rd_img, rest;
  logic [CBITS-1:0] head_q, head_d, tail_q, tail_d, head_mid;
  logic [CBITS:0]   count_q, count_d, cnt_mid;
  logic             alloc_req, alloc_ok, free, chk_full;

  always_comb begin
    map_c = commit_clear(map_q, bus.commit_v_i, bus.commit_tgt_i, bus.commit_id_i);
    map_n = map_c;
    img   = map_c;
    alloc_req = 1'b0;
    // Later slots overwrite earlier ones, so the highest slot wins; the
    // checkpoint image is snapshotted right after the branch slot's update.
    for (int i = 0; i < QSLOTS; i++) begin
      if (bus.slot_v_i[i] && bus.slot_rfw_i[i] && (bus.slot_rd_i[i] != '0))
        map_n[bus.slot_rd_i[i]] = {1'b1, bus.slot_rid_i[i]};
      if (bus.slot_v_i[i] && bus.slot_br_i[i] && !alloc_req) begin
        img       = map_n;
        alloc_req = 1'b1;
      end
    end
    rest = commit_clear(rd_img, bus.commit_v_i, bus.commit_tgt_i, bus.commit_id_i);

    chk_full = (count_q == (CBITS+1)'(NCHKPT));
    alloc_ok = alloc_req && !chk_full && !bus.branchmiss_i;
    map_d    = bus.branchmiss_i ? rest : map_n;

    // Rewind first, then let br_ok free the oldest surviving checkpoint.
    if (bus.branchmiss_i) begin
      head_mid = bus.miss_chk_i;
      cnt_mid  = {1'b0, bus.miss_chk_i - tail_q};
    end else begin
      head_mid = head_q;
      cnt_mid  = count_q;
    end
    free    = bus.br_ok_i && (cnt_mid != '0);
    head_d  = head_mid + CBITS'(alloc_ok);
    tail_d  = tail_q + CBITS'(free);
    count_d = cnt_mid + (CBITS+1)'(alloc_ok) - (CBITS+1)'(free);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      map_q   <= map_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  regfile_source_map_chkpt u_chkpt (
    .clk          (clk),
    .wr_en_i      (alloc_ok),
    .wr_idx_i     (head_q),
    .wr_img_i     (img),
    .rd_idx_i     (bus.miss_chk_i),
    .rd_img_o     (rd_img),
    .commit_v_i   (bus.commit_v_i),
    .commit_tgt_i (bus.commit_tgt_i),
    .commit_id_i  (bus.commit_id_i)
  );

  assign bus.rf_source_o = map_q;
  assign bus.chk_head_o  = head_q;
  assign bus.chk_full_o  = chk_full;

  // Protocol misuse is tolerated (request dropped) but flagged.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(alloc_req && chk_full && !bus.branchmiss_i))
        else $warning("branch checkpoint request dropped, all checkpoints busy");
      assert (!(bus.br_ok_i && (count_q == '0) && !bus.branchmiss_i))
        else $warning("br_ok with no outstanding checkpoint ignored");
    end
  end

endmodule
